// File: rtl/lcd_cmd_sched.sv
// Command scheduler for the LCD engine: queues host commands and issues them one at a time.
// Optional statistics counters are enabled with the LCD_SCHED_STATS_EN macro.
module lcd_cmd_sched #(
  parameter int         DEPTH = 8,
  parameter int         AW    = 3,
  parameter logic [3:0] NOP   = 4'hF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  output logic [3:0]    lcd_cmd,
  output logic          lcd_cmd_valid,
  input  logic          lcd_busy,
  input  logic          lcd_done,
  output logic [AW:0]   fifo_cnt,
  output logic          err_illegal,
  output logic          sched_done
`ifdef LCD_SCHED_STATS_EN
  ,
  output logic [15:0]   stat_issued,
  output logic [15:0]   stat_stall
`endif
);

  // Handshake: a host command transfers on any rising edge where host_valid
  // and host_ready are both high; host_ready is registered and never looks at host_valid.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [2:0]    state_q, state_d;
  logic          wr_seen_q, wr_seen_d;
  logic          host_ready_q, host_ready_d;
  logic [3:0]    lcd_cmd_q, lcd_cmd_d;
  logic          lcd_cmd_valid_q, lcd_cmd_valid_d;
  logic          err_illegal_q, err_illegal_d;
  logic          sched_done_q, sched_done_d;

  logic          accept;
  logic          legal;
  logic          push;
  logic          pop;
  logic [3:0]    head;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    cnt_d           = cnt_q;
    wr_seen_d       = wr_seen_q;
    lcd_cmd_d       = NOP;
    lcd_cmd_valid_d = 1'b0;
    pop             = 1'b0;

    accept        = host_valid && host_ready_q;
    legal         = (host_cmd < 4'd12);
    push          = accept && legal && (cnt_q < FULL);
    err_illegal_d = accept && !legal;
    if (accept && (host_cmd == 4'd0)) begin
      wr_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if ((cnt_q != '0) && !lcd_busy) begin
          state_d         = S_ISSUE;
          lcd_cmd_d       = head;
          lcd_cmd_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        pop     = 1'b1;
        state_d = (head == 4'd0) ? S_DRAIN : S_GAP;
      end
      S_GAP:    state_d = S_IDLE;
      S_DRAIN: begin
        if (lcd_done) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Ready is computed from next-cycle occupancy so a full FIFO or a seen WRITE blocks the very next cycle.
    host_ready_d = (cnt_d < FULL) && !wr_seen_d && (state_d != S_FINISH);
    sched_done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_cmd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      wr_seen_q       <= 1'b0;
      host_ready_q    <= 1'b0;
      lcd_cmd_q       <= NOP;
      lcd_cmd_valid_q <= 1'b0;
      err_illegal_q   <= 1'b0;
      sched_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      wr_seen_q       <= wr_seen_d;
      host_ready_q    <= host_ready_d;
      lcd_cmd_q       <= lcd_cmd_d;
      lcd_cmd_valid_q <= lcd_cmd_valid_d;
      err_illegal_q   <= err_illegal_d;
      sched_done_q    <= sched_done_d;
    end
  end

  assign host_ready    = host_ready_q;
  assign lcd_cmd       = lcd_cmd_q;
  assign lcd_cmd_valid = lcd_cmd_valid_q;
  assign fifo_cnt      = cnt_q;
  assign err_illegal   = err_illegal_q;
  assign sched_done    = sched_done_q;

`ifdef LCD_SCHED_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if ((state_q == S_ISSUE) && (stat_issued_q != 16'hFFFF)) begin
      stat_issued_d = stat_issued_q + 16'd1;
    end
    // A stall is an IDLE cycle where work is queued but the engine is busy.
    if ((state_q == S_IDLE) && (cnt_q != '0) && lcd_busy && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_q <= 16'd0;
      stat_stall_q  <= 16'd0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the scheduling rules.
module tb_lcd_cmd_sched;

  localparam int         DEPTH = 8;
  localparam int         AW    = 3;
  localparam logic [3:0] NOP   = 4'hF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    host_cmd = 4'd0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [3:0]    lcd_cmd;
  logic          lcd_cmd_valid;
  logic          lcd_busy = 1'b0;
  logic          lcd_done = 1'b0;
  logic [AW:0]   fifo_cnt;
  logic          err_illegal;
  logic          sched_done;
`ifdef LCD_SCHED_STATS_EN
  logic [15:0]   stat_issued;
  logic [15:0]   stat_stall;
`endif

  lcd_cmd_sched #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_cmd      (host_cmd),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .lcd_cmd       (lcd_cmd),
    .lcd_cmd_valid (lcd_cmd_valid),
    .lcd_busy      (lcd_busy),
    .lcd_done      (lcd_done),
    .fifo_cnt      (fifo_cnt),
    .err_illegal   (err_illegal),
    .sched_done    (sched_done)
`ifdef LCD_SCHED_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_stall    (stat_stall)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model: pending commands, session flags, and issue timing
  logic [3:0] exp_q[$];
  bit         m_wr_seen, m_drain, m_fin, last_acc;
  logic       m_ready, m_valid, m_err, m_done;
  logic [3:0] m_cmd;
  int         cyc, last_issue;
  int         m_issued, m_stall;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wr_seen = 0; m_drain = 0; m_fin = 0; last_acc = 0;
    m_ready = 0; m_valid = 0; m_err = 0; m_done = 0; m_cmd = NOP;
    cyc = 0; last_issue = -100;
    m_issued = 0; m_stall = 0;
  endtask

  // Advance the model by one clock given the inputs applied in this cycle.
  task automatic model_step(input logic hv, input logic [3:0] hc, input logic busy, input logic done);
    int   sz;
    bit   may_decide, decide, acc, nxt_fin;
    logic [3:0] nxt_cmd;
    sz         = exp_q.size();
    may_decide = !m_drain && !m_fin && (cyc >= last_issue + 2);
    decide     = may_decide && (sz > 0) && !busy;
    nxt_cmd    = decide ? exp_q[0] : NOP;
    acc        = hv && m_ready;
    nxt_fin    = m_fin || (m_drain && done);
    if (m_valid && m_issued < 65535) m_issued++;
    if (may_decide && sz > 0 && busy && m_stall < 65535) m_stall++;
    if (m_valid) begin
      if (exp_q[0] == 4'd0) m_drain = 1;
      void'(exp_q.pop_front());
    end
    m_err = acc && (hc >= 4'd12);
    if (acc && hc < 4'd12) exp_q.push_back(hc);
    if (acc && hc == 4'd0) m_wr_seen = 1;
    m_fin   = nxt_fin;
    m_valid = decide;
    m_cmd   = nxt_cmd;
    if (decide) last_issue = cyc + 1;
    m_ready  = (exp_q.size() < DEPTH) && !m_wr_seen && !m_fin;
    m_done   = m_fin;
    last_acc = acc;
    cyc++;
  endtask

  task automatic check_outputs();
    check("host_ready", 16'(host_ready), 16'(m_ready));
    check("lcd_cmd", 16'(lcd_cmd), 16'(m_cmd));
    check("lcd_cmd_valid", 16'(lcd_cmd_valid), 16'(m_valid));
    check("fifo_cnt", 16'(fifo_cnt), 16'(exp_q.size()));
    check("err_illegal", 16'(err_illegal), 16'(m_err));
    check("sched_done", 16'(sched_done), 16'(m_done));
`ifdef LCD_SCHED_STATS_EN
    check("stat_issued", stat_issued, 16'(m_issued));
    check("stat_stall", stat_stall, 16'(m_stall));
`endif
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic cycle(input logic hv, input logic [3:0] hc, input logic busy, input logic done);
    host_valid = hv; host_cmd = hc; lcd_busy = busy; lcd_done = done;
    #1;
    check_outputs();
    model_step(hv, hc, busy, done);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic busy);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, busy, 1'b0);
  endtask

  task automatic push_cmd(input logic [3:0] code, input logic busy);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(1'b1, code, busy, 1'b0);
      got = last_acc;
    end
    check("push_accepted", 16'(got), 16'd1);
    host_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    host_valid = 1'b0; host_cmd = 4'd0; lcd_busy = 1'b0; lcd_done = 1'b0;
    #1;
    check("rst_host_ready", 16'(host_ready), 16'd0);
    check("rst_lcd_cmd", 16'(lcd_cmd), 16'(NOP));
    check("rst_lcd_cmd_valid", 16'(lcd_cmd_valid), 16'd0);
    check("rst_fifo_cnt", 16'(fifo_cnt), 16'd0);
    check("rst_err_illegal", 16'(err_illegal), 16'd0);
    check("rst_sched_done", 16'(sched_done), 16'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic       r_hv, r_busy, r_done;
    logic [3:0] r_hc;
    model_reset();
    @(negedge clk);

    // 1: queued behind a busy engine, then issued in order with NOP gaps
    apply_reset();
    idle(1, 1'b1);
    push_cmd(4'd3, 1'b1);
    push_cmd(4'd4, 1'b1);
    push_cmd(4'd7, 1'b1);
    idle(60, 1'b1);
    idle(15, 1'b0);

    // 2: overflow attempt, ninth command waits for the first pop
    apply_reset();
    idle(1, 1'b1);
    for (int i = 1; i <= 8; i++) push_cmd(4'(i), 1'b1);
    check("full_cnt", 16'(fifo_cnt), 16'd8);
    check("full_ready", 16'(host_ready), 16'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'd9, 1'b1, 1'b0);
    push_cmd(4'd9, 1'b0);
    idle(40, 1'b0);

    // 3: illegal code dropped
    push_cmd(4'd13, 1'b0);
    idle(5, 1'b0);

    // 4: WRITE ends the session after lcd_done
    apply_reset();
    idle(1, 1'b0);
    push_cmd(4'd5, 1'b0);
    push_cmd(4'd0, 1'b0);
    idle(8, 1'b0);
    idle(64, 1'b1);
    cycle(1'b0, 4'd0, 1'b0, 1'b1);
    idle(5, 1'b0);
    check("done_sticky", 16'(sched_done), 16'd1);
    cycle(1'b1, 4'd2, 1'b0, 1'b0);

    // 5: reset during DRAIN and with queued work
    apply_reset();
    idle(1, 1'b0);
    push_cmd(4'd0, 1'b0);
    idle(4, 1'b0);
    apply_reset();
    idle(1, 1'b1);
    push_cmd(4'd2, 1'b1);
    push_cmd(4'd6, 1'b1);
    apply_reset();
    idle(3, 1'b0);

`ifdef LCD_SCHED_STATS_EN
    // 6: stall and issue counters
    apply_reset();
    push_cmd(4'd1, 1'b1);
    push_cmd(4'd2, 1'b1);
    idle(9, 1'b1);
    idle(12, 1'b0);
    check("stat_stall_10", stat_stall, 16'd10);
    check("stat_issued_2", stat_issued, 16'd2);
`endif

    // random sessions
    for (int s = 0; s < 5; s++) begin
      apply_reset();
      for (int i = 0; i < 200; i++) begin
        r_hv   = ($urandom_range(0, 2) != 0);
        r_hc   = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        r_busy = ($urandom_range(0, 3) == 0);
        r_done = ($urandom_range(0, 7) == 0);
        cycle(r_hv, r_hc, r_busy, r_done);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
